// File: rtl/divider_pkg.sv
// Shared arithmetic definitions for the divider: FSM states and counter sizing.
package divider_pkg;

    // Control states of the sequential divider.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width needed for a down-counter that is loaded with the operand width.
    function automatic int counter_width(input int bits);
        return $clog2(bits + 1);
    endfunction

    // Operand width used by the arithmetic unit when nothing else is specified.
    localparam int DEFAULT_BITS  = 8;
    localparam int DEFAULT_CNT_W = counter_width(DEFAULT_BITS);

endpackage

// File: rtl/divider_subtractor.sv
// Combinational (BITS+1)-bit trial subtractor; borrow means minuend < subtrahend.
module subtractor
    import divider_pkg::*;
#(
    parameter int BITS = DEFAULT_BITS
) (
    input  logic [BITS:0] i_minuend,
    input  logic [BITS:0] i_subtrahend,
    output logic [BITS:0] o_difference,
    output logic          o_borrow
);

    logic [BITS+1:0] full_diff;

    // One extra bit on the left captures the borrow out of the subtraction.
    assign full_diff    = {1'b0, i_minuend} - {1'b0, i_subtrahend};
    assign o_difference = full_diff[BITS:0];
    assign o_borrow     = full_diff[BITS+1];

endmodule

// File: rtl/divider.sv
// Sequential restoring divider: one quotient bit per clock, start/finished handshake.
module divider
    import divider_pkg::*;
#(
    parameter int BITS = DEFAULT_BITS
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_start,
    input  logic [BITS-1:0] i_dividend,
    input  logic [BITS-1:0] i_divisor,
    output logic            o_busy,
    output logic            o_finished,
    output logic [BITS-1:0] o_quotient,
    output logic [BITS-1:0] o_remainder,
    output logic            o_div_by_zero
);

    localparam int               CNT_W    = counter_width(BITS);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [BITS:0]    rem_q, rem_d;
    logic [BITS-1:0]  shq_q, shq_d;
    logic [BITS-1:0]  divisor_q, divisor_d;
    logic [BITS-1:0]  quot_q, quot_d;
    logic [BITS-1:0]  remout_q, remout_d;
    logic             dbz_q, dbz_d;

    logic [BITS:0]    rem_shift;
    logic [BITS:0]    trial;
    logic             borrow;
    logic [BITS:0]    iter_rem;
    logic [BITS-1:0]  iter_q;
    logic             load;

    // Shift {rem, q} left by one: the quotient register's MSB enters the remainder.
    // The remainder's top bit is always 0 here, so dropping it loses nothing.
    assign rem_shift = {rem_q[BITS-1:0], shq_q[BITS-1]};

    subtractor #(.BITS(BITS)) u_subtractor (
        .i_minuend    (rem_shift),
        .i_subtrahend ({1'b0, divisor_q}),
        .o_difference (trial),
        .o_borrow     (borrow)
    );

    // Restoring step: keep the trial difference only when it did not borrow.
    assign iter_rem = borrow ? rem_shift : trial;
    assign iter_q   = {shq_q[BITS-2:0], ~borrow};

    // A start is honoured only when no division is in flight.
    assign load = i_start && (state_q == IDLE || state_q == DONE);

    // Next-state, iteration and result-capture logic.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        rem_d     = rem_q;
        shq_d     = shq_q;
        divisor_d = divisor_q;
        quot_d    = quot_q;
        remout_d  = remout_q;
        dbz_d     = dbz_q;

        case (state_q)
            IDLE: state_d = IDLE;
            RUN: begin
                rem_d   = iter_rem;
                shq_d   = iter_q;
                count_d = count_q - 1'b1;
                if (count_q == CNT_LAST) begin
                    state_d  = DONE;
                    quot_d   = iter_q;
                    remout_d = iter_rem[BITS-1:0];
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (load) begin
            state_d   = RUN;
            count_d   = CNT_LOAD;
            divisor_d = i_divisor;
            shq_d     = i_dividend;
            rem_d     = '0;
            quot_d    = '0;
            remout_d  = '0;
            dbz_d     = (i_divisor == '0);
        end
    end

    // Control and result registers, cleared by the synchronous reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            quot_q   <= '0;
            remout_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            quot_q   <= quot_d;
            remout_q <= remout_d;
            dbz_q    <= dbz_d;
        end
    end

    // Working datapath registers; always reloaded by a start, so no reset needed.
    always_ff @(posedge i_clock) begin
        rem_q     <= rem_d;
        shq_q     <= shq_d;
        divisor_q <= divisor_d;
    end

    assign o_busy        = (state_q == RUN);
    assign o_finished    = (state_q == DONE);
    assign o_quotient    = quot_q;
    assign o_remainder   = remout_q;
    assign o_div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider.sv
// Testbench for the sequential restoring divider (BITS = 8).
module tb_divider;

    localparam int BITS = 8;

    logic            clk;
    logic            rst;
    logic            start;
    logic [BITS-1:0] dvd;
    logic [BITS-1:0] dvs;
    logic            busy;
    logic            finished;
    logic [BITS-1:0] quot;
    logic [BITS-1:0] remd;
    logic            dbz;

    divider #(.BITS(BITS)) dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_start       (start),
        .i_dividend    (dvd),
        .i_divisor     (dvs),
        .o_busy        (busy),
        .o_finished    (finished),
        .o_quotient    (quot),
        .o_remainder   (remd),
        .o_div_by_zero (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [BITS-1:0] a;
        logic [BITS-1:0] b;
        logic [BITS-1:0] q;
        logic [BITS-1:0] r;
        logic            z;
    } vec_t;

    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Called at a negedge: drive a start for one edge and record the expected result.
    task automatic start_op(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                            input logic [BITS-1:0] eq, input logic [BITS-1:0] er,
                            input logic ez);
        vec_t v;
        v.a = a; v.b = b; v.q = eq; v.r = er; v.z = ez;
        start = 1'b1;
        dvd   = a;
        dvs   = b;
        sb.push_back(v);
        tick();
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("finished_after_start", finished, 0);
    endtask

    // Wait (bounded) for the finished pulse; k0 = edges already elapsed since the start edge.
    task automatic wait_done(input int k0);
        int   k;
        vec_t e;
        k = k0;
        while (!finished && k < 4 * BITS) begin
            tick();
            k++;
        end
        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL timeout: no finished pulse after %0d cycles, required %0d", k + 1, BITS + 1);
            sb.delete();
        end else begin
            check("latency_cycles", k + 1, BITS + 1);
            check("busy_in_done", busy, 0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard: finished pulse with no pending request");
            end else begin
                e = sb.pop_front();
                check("quotient", quot, e.q);
                check("remainder", remd, e.r);
                check("div_by_zero", dbz, e.z);
            end
        end
    endtask

    vec_t vecs[8];

    initial begin
        logic [BITS-1:0] ra;
        logic [BITS-1:0] rb;
        int              pulses;

        vecs[0] = '{a: 8'd100, b: 8'd7,   q: 8'd14,  r: 8'd2,   z: 1'b0};
        vecs[1] = '{a: 8'd255, b: 8'd1,   q: 8'd255, r: 8'd0,   z: 1'b0};
        vecs[2] = '{a: 8'd7,   b: 8'd9,   q: 8'd0,   r: 8'd7,   z: 1'b0};
        vecs[3] = '{a: 8'd200, b: 8'd0,   q: 8'd255, r: 8'd200, z: 1'b1};
        vecs[4] = '{a: 8'd0,   b: 8'd5,   q: 8'd0,   r: 8'd0,   z: 1'b0};
        vecs[5] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,   z: 1'b0};
        vecs[6] = '{a: 8'd254, b: 8'd255, q: 8'd0,   r: 8'd254, z: 1'b0};
        vecs[7] = '{a: 8'd1,   b: 8'd0,   q: 8'd255, r: 8'd1,   z: 1'b1};

        rst   = 1'b1;
        start = 1'b0;
        dvd   = '0;
        dvs   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_finished", finished, 0);
        check("reset_quotient", quot, 0);
        check("reset_remainder", remd, 0);
        check("reset_dbz", dbz, 0);
        rst = 1'b0;
        tick();

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z);
            wait_done(0);
            tick();
            check("finished_one_cycle", finished, 0);
            check("quotient_held", quot, vecs[i].q);
            check("remainder_held", remd, vecs[i].r);
            tick();
        end

        // Random operands against a behavioural model.
        for (int i = 0; i < 8; i++) begin
            ra = BITS'($urandom_range(0, 255));
            rb = BITS'($urandom_range(0, 15));
            if (rb == 0)
                start_op(ra, rb, 8'hFF, ra, 1'b1);
            else
                start_op(ra, rb, ra / rb, ra % rb, 1'b0);
            wait_done(0);
            tick();
        end

        // A start during RUN is ignored; then a back-to-back start in the DONE cycle.
        start_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
        tick();
        tick();
        start = 1'b1;
        dvd   = 8'd50;
        dvs   = 8'd5;
        tick();
        start = 1'b0;
        dvd   = '0;
        dvs   = '0;
        wait_done(3);
        start_op(8'd50, 8'd5, 8'd10, 8'd0, 1'b0);
        wait_done(0);
        tick();

        // Reset in the middle of RUN.
        start_op(8'd100, 8'd7, 8'd14, 8'd2, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        check("midreset_busy", busy, 0);
        check("midreset_finished", finished, 0);
        check("midreset_quotient", quot, 0);
        check("midreset_remainder", remd, 0);
        check("midreset_dbz", dbz, 0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (finished) pulses++;
            tick();
        end
        check("midreset_no_finished", pulses, 0);
        start_op(8'd9, 8'd3, 8'd3, 8'd0, 1'b0);
        wait_done(0);
        tick();

        // Start and reset together: reset wins.
        rst   = 1'b1;
        start = 1'b1;
        dvd   = 8'd10;
        dvs   = 8'd2;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check("reset_start_busy", busy, 0);
        check("reset_start_quotient", quot, 0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (finished || busy) pulses++;
            tick();
        end
        check("reset_start_no_activity", pulses, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/divider.md
# divider

Sequential restoring divider computing `quotient = dividend / divisor` and `remainder = dividend % divisor` for unsigned BITS-wide operands. It produces one quotient bit per clock using shift-and-subtract, with a start/finished handshake. It sits beside the shift-add multiplier in the arithmetic unit and is its inverse operation.

## Interface
- `BITS`, default 8: operand, quotient and remainder width; must be ≥ 2.
- `i_clock` input 1: rising-edge clock.
- `i_reset` input 1: synchronous, active-high reset.
- `i_start` input 1: request a division; sampled on the rising edge.
- `i_dividend` input BITS: unsigned dividend, captured when a start is accepted.
- `i_divisor` input BITS: unsigned divisor, captured when a start is accepted.
- `o_busy` input-free output 1: high while iterations are in progress.
- `o_finished` output 1: one-cycle pulse; results are valid and stable in this cycle.
- `o_quotient` output BITS: quotient, held until the next accepted start.
- `o_remainder` output BITS: remainder, held until the next accepted start.
- `o_div_by_zero` output 1: set when the captured divisor was 0; held with the results.

## Operation
- State machine states:
  - IDLE: waiting for a start.
  - RUN: iterating; a down-counter holds the remaining iterations.
  - DONE: one cycle; `o_finished`=1.
- Transitions:
  - IDLE→RUN and DONE→RUN on `i_start`=1.
  - RUN→DONE when the counter reaches its last iteration.
  - DONE→IDLE when `i_start`=0.
- Accepted start:
  - Captures the divisor.
  - Loads the dividend into the quotient/shift register.
  - Clears the partial remainder (BITS+1 bits) and the result registers.
  - Sets `o_div_by_zero` = (divisor==0).
  - Loads the counter with BITS.
- Each RUN iteration (restoring step):
  - Shift: `{rem, q} <= {rem, q} << 1`.
  - Trial: `trial = rem_shifted − {1'b0, divisor}`, computed (BITS+1) bits wide.
  - No borrow: `rem <= trial`, `q[0] <= 1`.
  - Borrow: `rem` keeps the shifted value, `q[0] <= 0`.
- `i_start` while in RUN is ignored. Inputs are not re-sampled and the counter is undisturbed.
- Divide by zero takes no special datapath. The algorithm naturally yields quotient = all ones and remainder = dividend. Latency is unchanged and `o_div_by_zero`=1.
- Results:
  - `o_quotient`/`o_remainder` update only on the RUN→DONE edge.
  - The remainder output is the low BITS bits of `rem`; the top bit is 0 by construction.

## Timing
- Reset values:
  - State = IDLE.
  - `o_busy`=0, `o_finished`=0.
  - `o_quotient`=0, `o_remainder`=0, `o_div_by_zero`=0.
- Start accepted at edge E0. Iterations occur on edges E1..E_BITS.
- After E_BITS the state is DONE: `o_finished`=1 and results are valid.
- Latency is BITS+1 cycles from the start edge to the finished cycle, independent of operand values.
- `o_busy` is high in the cycles between E0 and E_BITS, and low in DONE and IDLE.
- Back-to-back operation: `i_start`=1 during the DONE cycle is accepted. `o_finished` still pulses for exactly that cycle, and the new operation's results replace the old ones at its own DONE.
- Reset asserted mid-RUN wins on that edge. It returns to IDLE with all outputs cleared and no `o_finished` pulse.
- `i_start` and `i_reset` asserted together: reset wins.

## Structure
- Shared arithmetic package holds:
  - the state enum (IDLE, RUN, DONE);
  - the counter width constant `$clog2(BITS+1)`.
- One natural sub-module, `subtractor` (parameter `BITS`):
  - Inputs: minuend and subtrahend, BITS+1 wide.
  - Outputs: difference and borrow.
  - Purely combinational, and instantiated once for the trial subtraction.
- Control, remainder register, quotient shift register and result registers all live in `divider`.

## Test plan
- BITS=8: start with 100 ÷ 7.
  - `o_finished` pulses exactly 9 cycles after the start edge.
  - `o_quotient`=14, `o_remainder`=2, `o_div_by_zero`=0.
- 255 ÷ 1 → quotient 255, remainder 0.
- 7 ÷ 9 → quotient 0, remainder 7.
- 200 ÷ 0 → quotient 255, remainder 200, `o_div_by_zero`=1, same 9-cycle latency.
- Start 100 ÷ 7, then pulse `i_start` with 50 ÷ 5 at cycle 3:
  - The second request is ignored.
  - Results are 14/2 at cycle 9.
  - A fresh start in the DONE cycle with 50 ÷ 5 yields 10/0 nine cycles later.
- Start 100 ÷ 7, assert `i_reset` at cycle 4:
  - All outputs read 0 from the next cycle.
  - No `o_finished` pulse occurs.
  - A subsequent 9 ÷ 3 yields 3/0.
